// File: rtl/echo_seq_pkg.sv
// Shared types and default constants for the echo frame sequencer.
// Holds the FSM state encoding and a helper that marks the enable-pulse states.
package echo_seq_pkg;

    localparam int DOUBLE_W          = 64;
    localparam int CNT_W_DEF         = 13;
    localparam int EN_PULSE_DEF      = 4;
    localparam int READY_TIMEOUT_DEF = 3000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV_EN,
        S_CONV_WAIT,
        S_LAG_EN,
        S_LAG_WAIT,
        S_PROC_EN,
        S_PROC_WAIT,
        S_OUTPUT
    } seq_state_t;

    function automatic logic is_en_state(input seq_state_t s);
        return (s == S_CONV_EN) || (s == S_LAG_EN) || (s == S_PROC_EN);
    endfunction

endpackage

// File: rtl/echo_frame_sequencer_if.sv
// Bundle between the sequencer and the sampling counter / datapath stages.
// master = sequencer side, slave = counter/datapath side.
interface echo_frame_sequencer_if #(
    parameter int CNT_W = echo_seq_pkg::CNT_W_DEF
);
    logic                              run;
    logic                              adapt_mode;
    logic [CNT_W-1:0]                  sampling_cycle_counter;
    logic                              ready_conv;
    logic                              ready_lag;
    logic                              ready_adapt;
    logic                              ready_cancel;
    logic [echo_seq_pkg::DOUBLE_W-1:0] e;
    logic [echo_seq_pkg::DOUBLE_W-1:0] signal_without_echo;
    logic                              enable_conv;
    logic                              enable_lag;
    logic                              enable_adapt;
    logic                              enable_cancel;
    logic                              enable_out;
    logic [echo_seq_pkg::DOUBLE_W-1:0] double_out;
    logic                              busy;
    logic                              timeout_err;
    logic                              overrun_err;
    logic [15:0]                       frame_count;
    logic [CNT_W-1:0]                  max_latency;

    modport master (
        input  run, adapt_mode, sampling_cycle_counter,
        input  ready_conv, ready_lag, ready_adapt, ready_cancel,
        input  e, signal_without_echo,
        output enable_conv, enable_lag, enable_adapt, enable_cancel,
        output enable_out, double_out, busy, timeout_err, overrun_err,
        output frame_count, max_latency
    );

    modport slave (
        output run, adapt_mode, sampling_cycle_counter,
        output ready_conv, ready_lag, ready_adapt, ready_cancel,
        output e, signal_without_echo,
        input  enable_conv, enable_lag, enable_adapt, enable_cancel,
        input  enable_out, double_out, busy, timeout_err, overrun_err,
        input  frame_count, max_latency
    );
endinterface

// File: rtl/echo_frame_sequencer_stage_handshake.sv
// Shared per-stage handshake: enable pulse length, stale-ready rejection and ready timeout.
// Restarted on every X_EN entry; ready only counts once it has been seen low since the pulse began.
module stage_handshake #(
    parameter int EN_PULSE      = echo_seq_pkg::EN_PULSE_DEF,
    parameter int READY_TIMEOUT = echo_seq_pkg::READY_TIMEOUT_DEF
) (
    input  logic clk_operation,
    input  logic rst,
    input  logic i_restart,
    input  logic i_in_en,
    input  logic i_in_wait,
    input  logic i_ready,
    output logic o_pulse_last,
    output logic o_qual,
    output logic o_timeout
);
    localparam int PW = $clog2(EN_PULSE + 1);
    localparam int TW = $clog2(READY_TIMEOUT + 1);

    logic [PW-1:0] r_pulse_cnt;
    logic [TW-1:0] r_wait_cnt;
    logic          r_low_seen;

    always_ff @(posedge clk_operation) begin
        if (rst || i_restart) begin
            r_pulse_cnt <= '0;
            r_wait_cnt  <= '0;
            r_low_seen  <= 1'b0;
        end else begin
            if (i_in_en)
                r_pulse_cnt <= r_pulse_cnt + PW'(1);
            if (i_in_wait && (r_wait_cnt != TW'(READY_TIMEOUT)))
                r_wait_cnt <= r_wait_cnt + TW'(1);
            if ((i_in_en || i_in_wait) && !i_ready)
                r_low_seen <= 1'b1;
        end
    end

    assign o_pulse_last = i_in_en && (r_pulse_cnt == PW'(EN_PULSE - 1));
    // The low sample is registered, so the qualifying high must come in a later cycle.
    assign o_qual       = i_in_wait && r_low_seen && i_ready;
    assign o_timeout    = i_in_wait && (r_wait_cnt == TW'(READY_TIMEOUT));

endmodule

// File: rtl/echo_frame_sequencer.sv
// Per-sample sequencer: conv -> lag -> adapt|cancel -> output load, one frame per counter==0.
// Optional stats (frame_count, max_latency) built only with ECHO_SEQ_STATS_EN defined.
module echo_frame_sequencer
    import echo_seq_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int EN_PULSE      = EN_PULSE_DEF,
    parameter int READY_TIMEOUT = READY_TIMEOUT_DEF
) (
    input  logic                   clk_operation,
    input  logic                   rst,
    echo_frame_sequencer_if.master bus
);
    seq_state_t            r_state;
    seq_state_t            w_next;
    logic                  r_mode_q;
    logic [DOUBLE_W-1:0]   r_double_out;
    logic                  r_timeout_err;
    logic                  r_overrun_err;
    logic                  w_start_frame;
    logic                  w_in_en;
    logic                  w_in_wait;
    logic                  w_ready;
    logic                  w_restart;
    logic                  w_pulse_last;
    logic                  w_qual;
    logic                  w_timeout;
    logic                  w_timeout_hit;
    logic                  w_load_out;

    assign w_start_frame = bus.run && (bus.sampling_cycle_counter == '0);
    assign w_in_en       = is_en_state(r_state);
    assign w_in_wait     = (r_state == S_CONV_WAIT) || (r_state == S_LAG_WAIT) ||
                           (r_state == S_PROC_WAIT);
    assign w_restart     = is_en_state(w_next) && (w_next != r_state);

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_CONV_EN, S_CONV_WAIT: w_ready = bus.ready_conv;
            S_LAG_EN,  S_LAG_WAIT:  w_ready = bus.ready_lag;
            S_PROC_EN, S_PROC_WAIT: w_ready = r_mode_q ? bus.ready_adapt : bus.ready_cancel;
            default:                w_ready = 1'b0;
        endcase
    end

    stage_handshake #(
        .EN_PULSE      (EN_PULSE),
        .READY_TIMEOUT (READY_TIMEOUT)
    ) u_handshake (
        .clk_operation (clk_operation),
        .rst           (rst),
        .i_restart     (w_restart),
        .i_in_en       (w_in_en),
        .i_in_wait     (w_in_wait),
        .i_ready       (w_ready),
        .o_pulse_last  (w_pulse_last),
        .o_qual        (w_qual),
        .o_timeout     (w_timeout)
    );

    assign w_timeout_hit = w_in_wait && !w_qual && w_timeout;

    always_comb begin
        w_next     = r_state;
        w_load_out = 1'b0;
        case (r_state)
            S_IDLE:      if (w_start_frame) w_next = S_CONV_EN;
            S_CONV_EN:   if (w_pulse_last)  w_next = S_CONV_WAIT;
            S_CONV_WAIT: if (w_qual)        w_next = S_LAG_EN;
                         else if (w_timeout) w_next = S_IDLE;
            S_LAG_EN:    if (w_pulse_last)  w_next = S_LAG_WAIT;
            S_LAG_WAIT:  if (w_qual)        w_next = S_PROC_EN;
                         else if (w_timeout) w_next = S_IDLE;
            S_PROC_EN:   if (w_pulse_last)  w_next = S_PROC_WAIT;
            S_PROC_WAIT: if (w_qual) begin
                             w_next     = S_OUTPUT;
                             w_load_out = 1'b1;
                         end else if (w_timeout) begin
                             w_next = S_IDLE;
                         end
            S_OUTPUT:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // double_out is loaded on entry to OUTPUT so it is already valid alongside enable_out.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mode_q      <= 1'b0;
            r_double_out  <= '0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && w_start_frame)
                r_mode_q <= bus.adapt_mode;
            if (w_load_out)
                r_double_out <= r_mode_q ? bus.e : bus.signal_without_echo;
            if (w_timeout_hit)
                r_timeout_err <= 1'b1;
            if ((r_state != S_IDLE) && w_start_frame)
                r_overrun_err <= 1'b1;
        end
    end

    assign bus.enable_conv   = (r_state == S_CONV_EN);
    assign bus.enable_lag    = (r_state == S_LAG_EN);
    assign bus.enable_adapt  = (r_state == S_PROC_EN) && r_mode_q;
    assign bus.enable_cancel = (r_state == S_PROC_EN) && !r_mode_q;
    assign bus.enable_out    = (r_state == S_OUTPUT);
    assign bus.double_out    = r_double_out;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.timeout_err   = r_timeout_err;
    assign bus.overrun_err   = r_overrun_err;

`ifdef ECHO_SEQ_STATS_EN
    logic [15:0]      r_frame_count;
    logic [CNT_W-1:0] r_lat;
    logic [CNT_W-1:0] r_max_lat;

    // r_lat counts frame cycles inclusively: 1 in the first CONV_EN cycle.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            r_frame_count <= '0;
            r_lat         <= '0;
            r_max_lat     <= '0;
        end else begin
            if ((r_state == S_IDLE) && (w_next == S_CONV_EN))
                r_lat <= CNT_W'(1);
            else if ((r_state != S_IDLE) && (r_lat != {CNT_W{1'b1}}))
                r_lat <= r_lat + CNT_W'(1);
            if (r_state == S_OUTPUT) begin
                r_frame_count <= r_frame_count + 16'd1;
                if (r_lat > r_max_lat)
                    r_max_lat <= r_lat;
            end
        end
    end

    assign bus.frame_count = r_frame_count;
    assign bus.max_latency = r_max_lat;
`else
    assign bus.frame_count = '0;
    assign bus.max_latency = '0;
`endif

endmodule

// File: tb/tb_echo_frame_sequencer.sv
// Directed bench for echo_frame_sequencer: adapt/cancel frames, stale ready, overrun, run drop, mid-frame reset.
// Ready responders drop ready on each pulse and raise it 11 negedges after the pulse ends.
module tb_echo_frame_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    echo_frame_sequencer_if #(.CNT_W(13)) bus();

    echo_frame_sequencer dut (
        .clk_operation (clk),
        .rst           (rst),
        .bus           (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] rdy = 4'hF;
    logic [3:0] pend = 4'h0;
    int         rcnt[4];
    logic       stale_lag = 1'b0;

    logic [3:0] prev_en = 4'h0;
    int         run_len[4];
    int         order_q[$];
    int         width_q[$];
    int         cyc_n = 0;
    int         t0 = 0;
    int         lat_meas = 0;
    int         eo_cnt = 0;
    int         excl_viol = 0;

    function automatic logic [3:0] en_vec();
        return {bus.enable_cancel, bus.enable_adapt, bus.enable_lag, bus.enable_conv};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic mode);
        bus.adapt_mode = mode;
        bus.sampling_cycle_counter = '0;
        cyc(1);
        bus.sampling_cycle_counter = 13'd1;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k;
        k = 0;
        while (bus.busy && (k < bound)) begin
            cyc(1);
            k++;
        end
        chk(tag, 64'(bus.busy), 64'd0);
    endtask

    task automatic wait_en(input string tag, input int idx, input logic level, input int bound);
        int k;
        logic [3:0] v;
        k = 0;
        v = en_vec();
        while ((v[idx] !== level) && (k < bound)) begin
            cyc(1);
            k++;
            v = en_vec();
        end
        chk(tag, 64'(v[idx]), 64'(level));
    endtask

    task automatic check_frame(input string tag, input int last_stage,
                               input logic [63:0] exp_dout, input int eo_before);
        chk({tag, "_eo"}, 64'(eo_cnt - eo_before), 64'd1);
        chk({tag, "_nstages"}, 64'(order_q.size()), 64'd3);
        if (order_q.size() == 3) begin
            chk({tag, "_ord0"}, 64'(order_q[0]), 64'd0);
            chk({tag, "_ord1"}, 64'(order_q[1]), 64'd1);
            chk({tag, "_ord2"}, 64'(order_q[2]), 64'(last_stage));
        end
        foreach (width_q[i]) chk({tag, "_width"}, 64'(width_q[i]), 64'd4);
        chk({tag, "_dout"}, bus.double_out, exp_dout);
        chk({tag, "_lat"}, 64'(lat_meas), 64'd46);
    endtask

    // Ready responders for the four stages.
    initial begin
        forever begin
            logic [3:0] en;
            @(negedge clk);
            en = en_vec();
            for (int i = 0; i < 4; i++) begin
                if (en[i]) begin
                    rdy[i] = 1'b0;
                    pend[i] = 1'b1;
                    rcnt[i] = 0;
                end else if (pend[i]) begin
                    rcnt[i]++;
                    if (rcnt[i] == 11) begin
                        rdy[i] = 1'b1;
                        pend[i] = 1'b0;
                    end
                end
            end
            bus.ready_conv   = rdy[0];
            bus.ready_lag    = rdy[1] | stale_lag;
            bus.ready_adapt  = rdy[2];
            bus.ready_cancel = rdy[3];
        end
    end

    // Pulse order, width, latency and exclusivity monitor.
    initial begin
        forever begin
            logic [3:0] en;
            @(negedge clk);
            cyc_n++;
            en = en_vec();
            if ($countones({en, bus.enable_out}) > 1) excl_viol++;
            for (int i = 0; i < 4; i++) begin
                if (en[i]) begin
                    if (!prev_en[i]) order_q.push_back(i);
                    run_len[i]++;
                end else if (prev_en[i]) begin
                    width_q.push_back(run_len[i]);
                    run_len[i] = 0;
                end
            end
            if (en[0] && !prev_en[0]) t0 = cyc_n;
            if (bus.enable_out) begin
                eo_cnt++;
                lat_meas = cyc_n - t0 + 1;
            end
            prev_en = en;
        end
    end

    initial begin
        int eo0;
        bus.run = 1'b1;
        bus.adapt_mode = 1'b0;
        bus.sampling_cycle_counter = 13'd1;
        bus.e = 64'h3FD0000000000000;
        bus.signal_without_echo = 64'hBFF0000000000000;
        bus.ready_conv = 1'b1;
        bus.ready_lag = 1'b1;
        bus.ready_adapt = 1'b1;
        bus.ready_cancel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rcnt[i] = 0;
            run_len[i] = 0;
        end

        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_en", 64'({en_vec(), bus.enable_out}), 64'd0);
        chk("rst_dout", bus.double_out, 64'd0);
        chk("rst_flags", 64'({bus.timeout_err, bus.overrun_err}), 64'd0);
        chk("rst_stats", 64'({bus.frame_count, bus.max_latency}), 64'd0);

        // Adapt frame
        order_q.delete(); width_q.delete(); eo0 = eo_cnt;
        start_frame(1'b1);
        wait_idle("adapt_done", 200);
        check_frame("adapt", 2, 64'h3FD0000000000000, eo0);

        // Cancel frame
        cyc(5);
        order_q.delete(); width_q.delete(); eo0 = eo_cnt;
        start_frame(1'b0);
        wait_idle("cancel_done", 200);
        check_frame("cancel", 3, 64'hBFF0000000000000, eo0);
        chk("cancel_flags", 64'({bus.timeout_err, bus.overrun_err}), 64'd0);

        // Stale ready on the lag stage
        cyc(5);
        stale_lag = 1'b1; eo0 = eo_cnt;
        start_frame(1'b1);
        wait_en("stale_lag_hi", 1, 1'b1, 100);
        wait_en("stale_lag_lo", 1, 1'b0, 100);
        cyc(2995);
        chk("stale_early_to", 64'(bus.timeout_err), 64'd0);
        chk("stale_early_busy", 64'(bus.busy), 64'd1);
        cyc(20);
        chk("stale_to", 64'(bus.timeout_err), 64'd1);
        chk("stale_idle", 64'(bus.busy), 64'd0);
        chk("stale_no_eo", 64'(eo_cnt - eo0), 64'd0);
        stale_lag = 1'b0;

        // Overrun while in PROC_WAIT
        cyc(5);
        order_q.delete(); width_q.delete(); eo0 = eo_cnt;
        chk("ovr_pre", 64'(bus.overrun_err), 64'd0);
        start_frame(1'b1);
        wait_en("ovr_adapt_hi", 2, 1'b1, 100);
        wait_en("ovr_adapt_lo", 2, 1'b0, 100);
        cyc(2);
        bus.sampling_cycle_counter = '0;
        cyc(1);
        bus.sampling_cycle_counter = 13'd1;
        chk("ovr_flag", 64'(bus.overrun_err), 64'd1);
        chk("ovr_busy", 64'(bus.busy), 64'd1);
        wait_idle("ovr_done", 200);
        check_frame("ovr", 2, 64'h3FD0000000000000, eo0);
        cyc(5);
        chk("ovr_no_restart", 64'(bus.busy), 64'd0);

        // run drops mid-frame
        order_q.delete(); width_q.delete(); eo0 = eo_cnt;
        start_frame(1'b0);
        bus.run = 1'b0;
        wait_idle("rundrop_done", 200);
        chk("rundrop_eo", 64'(eo_cnt - eo0), 64'd1);
        bus.sampling_cycle_counter = '0;
        cyc(3);
        chk("rundrop_no_start", 64'(bus.busy), 64'd0);
        bus.sampling_cycle_counter = 13'd1;
        bus.run = 1'b1;

        // Reset during LAG_EN
        cyc(2);
        eo0 = eo_cnt;
        start_frame(1'b1);
        wait_en("rst_lag_hi", 1, 1'b1, 100);
        rst = 1'b1;
        cyc(1);
        chk("mrst_en", 64'({en_vec(), bus.enable_out}), 64'd0);
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_flags", 64'({bus.timeout_err, bus.overrun_err}), 64'd0);
        chk("mrst_dout", bus.double_out, 64'd0);
        rst = 1'b0;
        cyc(20);
        chk("mrst_quiet", 64'(eo_cnt - eo0), 64'd0);

        // Three clean frames after reset
        for (int f = 0; f < 3; f++) begin
            cyc(3);
            order_q.delete(); width_q.delete(); eo0 = eo_cnt;
            start_frame(f[0]);
            wait_idle("clean_done", 200);
            check_frame("clean", f[0] ? 2 : 3,
                        f[0] ? 64'h3FD0000000000000 : 64'hBFF0000000000000, eo0);
        end
        chk("clean_flags", 64'({bus.timeout_err, bus.overrun_err}), 64'd0);
`ifdef ECHO_SEQ_STATS_EN
        chk("stats_frames", 64'(bus.frame_count), 64'd3);
        chk("stats_maxlat", 64'(bus.max_latency), 64'd46);
`else
        chk("stats_frames_off", 64'(bus.frame_count), 64'd0);
        chk("stats_maxlat_off", 64'(bus.max_latency), 64'd0);
`endif
        chk("exclusive", 64'(excl_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
